// File: rtl/ec2_control_unit_pkg.sv
// Shared constants for the EC2 accumulator machine: opcodes, FSM state
// encodings, A-mux selects and default widths.
package ec2_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int PC_W_DEF   = 5;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_INPUT = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  // Execute states sit at 8 + opcode; 4..7 are unused.
  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_IN_REL = 4'd3,
    S_LOAD   = 4'd8,
    S_STORE  = 4'd9,
    S_ADD    = 4'd10,
    S_SUB    = 4'd11,
    S_INPUT  = 4'd12,
    S_JZ     = 4'd13,
    S_JPOS   = 4'd14,
    S_HALT   = 4'd15
  } state_t;

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_IN  = 2'b01;
  localparam logic [1:0] SEL_RAM = 2'b10;

endpackage

// File: rtl/ec2_control_unit.sv
// EC2 control unit: owns PC and IR, sequences fetch/decode/execute and
// drives the datapath strobes, keypad handshake and halt indication.
module ec2_control_unit
  import ec2_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W   = PC_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enter,
  input  logic [DATA_W-1:0] instr_data,
  input  logic              a_zero,
  input  logic              a_pos,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   ram_addr,
  output logic              ram_wr,
  output logic              a_load,
  output logic [1:0]        a_sel,
  output logic              alu_sub,
  output logic              halt,
  output logic [3:0]        state,
  output logic [2:0]        ir_op
);

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q;
  logic [DATA_W-1:0]   ir_q;
  logic [2:0]          op;

  assign op       = ir_q[DATA_W-1 -: 3];
  assign pc       = pc_q;
  assign ram_addr = ir_q[PC_W-1:0];
  assign ir_op    = op;
  assign state    = state_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_START;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_FETCH: begin
          ir_q <= instr_data;
          pc_q <= pc_q + 1'b1;
        end
        S_JZ:    if (a_zero) pc_q <= ir_q[PC_W-1:0];
        S_JPOS:  if (a_pos)  pc_q <= ir_q[PC_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    ram_wr  = 1'b0;
    a_load  = 1'b0;
    a_sel   = SEL_ALU;
    alu_sub = 1'b0;
    halt    = 1'b0;
    case (state_q)
      S_START:  state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD:  state_d = S_LOAD;
          OP_STORE: state_d = S_STORE;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_INPUT: state_d = S_INPUT;
          OP_JZ:    state_d = S_JZ;
          OP_JPOS:  state_d = S_JPOS;
          default:  state_d = S_HALT;
        endcase
      end
      S_LOAD: begin
        a_sel   = SEL_RAM;
        a_load  = 1'b1;
        state_d = S_FETCH;
      end
      S_STORE: begin
        ram_wr  = 1'b1;
        state_d = S_FETCH;
      end
      S_ADD: begin
        a_load  = 1'b1;
        state_d = S_FETCH;
      end
      S_SUB: begin
        alu_sub = 1'b1;
        a_load  = 1'b1;
        state_d = S_FETCH;
      end
      // One load per press; IN_REL then waits for the key to be released.
      S_INPUT: begin
        if (Enter) begin
          a_sel   = SEL_IN;
          a_load  = 1'b1;
          state_d = S_IN_REL;
        end
      end
      S_IN_REL: if (!Enter) state_d = S_FETCH;
      S_JZ, S_JPOS: state_d = S_FETCH;
      S_HALT:   halt = 1'b1;
      default:  state_d = S_START;
    endcase
    // Keep the datapath quiet during the reset cycle whatever state we were in.
    if (Reset) begin
      ram_wr  = 1'b0;
      a_load  = 1'b0;
      a_sel   = SEL_ALU;
      alu_sub = 1'b0;
      halt    = 1'b0;
    end
  end

endmodule

// File: tb/tb_ec2_control_unit.sv
// Bench for ec2_control_unit: an instruction-level model walks each
// instruction through fetch/decode/execute and checks every cycle.
module tb_ec2_control_unit;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Enter = 1'b0;
  logic [7:0] instr_data;
  logic       a_zero = 1'b0;
  logic       a_pos = 1'b0;
  logic [4:0] pc, ram_addr;
  logic       ram_wr, a_load, alu_sub, halt;
  logic [1:0] a_sel;
  logic [3:0] state;
  logic [2:0] ir_op;

  logic [7:0] mem [32];
  int n_pass = 0;
  int n_total = 0;
  int exp_pc = 0;

  logic [5:0] strb;
  assign strb = {ram_wr, a_load, a_sel, alu_sub, halt};
  assign instr_data = mem[pc];

  ec2_control_unit dut (
    .Clock(Clock), .Reset(Reset), .Enter(Enter), .instr_data(instr_data),
    .a_zero(a_zero), .a_pos(a_pos), .pc(pc), .ram_addr(ram_addr),
    .ram_wr(ram_wr), .a_load(a_load), .a_sel(a_sel), .alu_sub(alu_sub),
    .halt(halt), .state(state), .ir_op(ir_op)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tk();
    @(posedge Clock);
    #1;
  endtask

  // Expected {ram_wr, a_load, a_sel, alu_sub, halt} in each execute state.
  function automatic logic [5:0] exec_strobes(input int op);
    case (op)
      0:       return 6'b011000; // LOAD: A <= RAM
      1:       return 6'b100000; // STORE
      2:       return 6'b010000; // ADD
      3:       return 6'b010010; // SUB
      7:       return 6'b000001; // HALT
      default: return 6'b000000;
    endcase
  endfunction

  task automatic fill(input int max_op);
    for (int i = 0; i < 32; i++)
      mem[i] = {3'($urandom_range(0, max_op)), 5'($urandom_range(0, 31))};
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Enter = 1'b0;
    tk();
    tk();
    chk("rst_state", state, 0);
    chk("rst_pc", pc, 0);
    chk("rst_strobes", strb, 0);
    chk("rst_irop", ir_op, 0);
    Reset = 1'b0;
    tk();
    chk("rst_to_fetch", state, 1);
    exp_pc = 0;
  endtask

  // flag: 0 -> A==0, 1 -> A>0, 2 -> A<0
  task automatic run_instr(input int wait_c, input int hold_c, input int flag, input bit abort);
    logic [7:0] ins;
    int op, addr;
    chk("fetch_state", state, 1);
    chk("fetch_pc", pc, exp_pc);
    chk("fetch_strobes", strb, 0);
    ins = mem[exp_pc];
    op = int'(ins[7:5]);
    addr = int'(ins[4:0]);
    exp_pc = (exp_pc + 1) % 32;
    tk();
    chk("dec_state", state, 2);
    chk("dec_irop", ir_op, op);
    chk("dec_addr", ram_addr, addr);
    chk("dec_pc", pc, exp_pc);
    chk("dec_strobes", strb, 0);
    tk();
    chk("exec_state", state, 8 + op);
    chk("exec_addr", ram_addr, addr);
    if (abort) begin
      if (op == 4) Enter = 1'b1;
      Reset = 1'b1;
      tk();
      chk("abort_state", state, 0);
      chk("abort_aload", a_load, 0);
      chk("abort_pc", pc, 0);
      Reset = 1'b0;
      Enter = 1'b0;
      tk();
      chk("abort_fetch", state, 1);
      exp_pc = 0;
      return;
    end
    case (op)
      0, 1, 2, 3: begin
        chk("exec_strobes", strb, exec_strobes(op));
        tk();
      end
      5, 6: begin
        a_zero = (flag == 0);
        a_pos  = (flag == 1);
        chk("jump_strobes", strb, 0);
        tk();
        if ((op == 5 && flag == 0) || (op == 6 && flag == 1)) exp_pc = addr;
      end
      4: begin
        for (int w = 0; w < wait_c; w++) begin
          chk("in_wait_state", state, 12);
          chk("in_wait_strobes", strb, 0);
          tk();
        end
        Enter = 1'b1;
        #1;
        chk("in_cap_state", state, 12);
        chk("in_cap_strobes", strb, 6'b010100);
        tk();
        for (int h = 1; h < hold_c; h++) begin
          chk("in_rel_state", state, 3);
          chk("in_rel_strobes", strb, 0);
          tk();
        end
        Enter = 1'b0;
        #1;
        chk("in_rel_last", state, 3);
        chk("in_rel_last_strobes", strb, 0);
        tk();
      end
      default: begin
        for (int c = 0; c < 20; c++) begin
          Enter = 1'($urandom_range(0, 1));
          #1;
          chk("halt_state", state, 15);
          chk("halt_strobes", strb, exec_strobes(7));
          chk("halt_pc", pc, exp_pc);
          tk();
        end
        Enter = 1'b0;
      end
    endcase
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed: LOAD, INPUT, JZ taken/not taken, JPOS not taken.
    fill(6);
    mem[0]  = 8'h05;
    mem[1]  = 8'h80;
    mem[2]  = 8'hB4;
    mem[20] = 8'hB4;
    mem[21] = 8'hC4;
    do_reset();
    run_instr(0, 1, 0, 0);
    run_instr(4, 3, 0, 0);
    run_instr(0, 1, 0, 0);
    chk("jz_taken_pc", pc, 20);
    run_instr(0, 1, 1, 0);
    chk("jz_not_taken_pc", pc, 21);
    run_instr(0, 1, 2, 0);
    chk("jpos_not_taken_pc", pc, 22);

    // Straight-line code so the PC wraps 31 -> 0.
    fill(4);
    do_reset();
    for (int i = 0; i < 40; i++)
      run_instr($urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 2), 0);

    // Random programs including jumps.
    fill(6);
    do_reset();
    for (int i = 0; i < 150; i++)
      run_instr($urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 2), 0);

    // Reset during SUB, then during INPUT with Enter held.
    mem[0] = 8'h63;
    do_reset();
    run_instr(0, 1, 0, 1);
    mem[0] = 8'h80;
    run_instr(0, 1, 0, 1);

    // HALT holds for 20 cycles with Enter toggling, then reset recovers.
    mem[0] = 8'hE0;
    run_instr(0, 1, 0, 0);
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
